// File: rtl/emmc_clk_seq_pkg.sv
// emmc_clk_seq_pkg: shared state encoding, widths and settings reset values for the card-clock reconfiguration sequencer
package emmc_clk_seq_pkg;
    localparam int MUX_W   = 2;
    localparam int PHASE_W = 7;
    localparam int CNT_W   = 16;
    typedef enum logic [2:0] {IDLE, GATE, SETTLE1, APPLY, SETTLE2, ENABLE} state_t;
    localparam logic [MUX_W-1:0]   MUX_RST  = '0;
    localparam logic [PHASE_W-1:0] DRV_RST  = '0;
    localparam logic [PHASE_W-1:0] SMPL_RST = '0;
endpackage

// File: rtl/emmc_sync2.sv
// emmc_sync2: two-flop synchronizer for asynchronous status inputs, resets to 0
module emmc_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, meta} <= '0;
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/emmc_clk_reconfig_seq.sv
// emmc_clk_reconfig_seq: gates the card clock, applies mux/phase settings in a quiet window, re-enables with bounded handshakes
module emmc_clk_reconfig_seq
    import emmc_clk_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [MUX_W-1:0]   req_mux_ctrl,
    input  logic [PHASE_W-1:0] req_drv_phase,
    input  logic [PHASE_W-1:0] req_smpl_phase,
    output logic               clk_enable,
    output logic [MUX_W-1:0]   ext_clk_mux_ctrl,
    output logic [PHASE_W-1:0] clk_drv_phase_ctrl,
    output logic [PHASE_W-1:0] clk_smpl_phase_ctrl,
    input  logic               clk_ready,
    output logic               busy,
    output logic               done,
    output logic               err_timeout
);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               rdy_s;
    logic               en_save;
    logic [MUX_W-1:0]   sh_mux;
    logic [PHASE_W-1:0] sh_drv;
    logic [PHASE_W-1:0] sh_smpl;

    emmc_sync2 #(.W(1)) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (clk_ready),
        .q     (rdy_s)
    );

    // cnt is cleared on every state change; the awaited level beats a coincident timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            cnt                 <= '0;
            req_ready           <= 1'b1;
            busy                <= 1'b0;
            done                <= 1'b0;
            err_timeout         <= 1'b0;
            clk_enable          <= 1'b0;
            en_save             <= 1'b0;
            ext_clk_mux_ctrl    <= MUX_RST;
            clk_drv_phase_ctrl  <= DRV_RST;
            clk_smpl_phase_ctrl <= SMPL_RST;
            sh_mux              <= MUX_RST;
            sh_drv              <= DRV_RST;
            sh_smpl             <= SMPL_RST;
        end else begin
            done        <= 1'b0;
            err_timeout <= 1'b0;
            cnt         <= cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_valid) begin
                        sh_mux     <= req_mux_ctrl;
                        sh_drv     <= req_drv_phase;
                        sh_smpl    <= req_smpl_phase;
                        en_save    <= clk_enable;
                        clk_enable <= 1'b0;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= GATE;
                    end
                end
                GATE: begin
                    if (!rdy_s) begin
                        cnt   <= '0;
                        state <= SETTLE1;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt         <= '0;
                        clk_enable  <= en_save;
                        err_timeout <= 1'b1;
                        req_ready   <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                SETTLE1: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    cnt                 <= '0;
                    ext_clk_mux_ctrl    <= sh_mux;
                    clk_drv_phase_ctrl  <= sh_drv;
                    clk_smpl_phase_ctrl <= sh_smpl;
                    state               <= SETTLE2;
                end
                SETTLE2: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt        <= '0;
                        clk_enable <= 1'b1;
                        state      <= ENABLE;
                    end
                end
                ENABLE: begin
                    if (rdy_s || cnt == TIMEOUT_LAST) begin
                        cnt         <= '0;
                        done        <= rdy_s;
                        err_timeout <= !rdy_s;
                        req_ready   <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_emmc_clk_reconfig_seq.sv
// tb_emmc_clk_reconfig_seq: randomized scenarios checked cycle by cycle against a timeline model of the sequencer
module tb_emmc_clk_reconfig_seq;
    localparam int S  = 4;
    localparam int TO = 32;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       clk_ready = 1'b0;
    logic [1:0] req_mux_ctrl = '0;
    logic [6:0] req_drv_phase = '0;
    logic [6:0] req_smpl_phase = '0;
    logic       req_ready, clk_enable, busy, done, err_timeout;
    logic [1:0] ext_clk_mux_ctrl;
    logic [6:0] clk_drv_phase_ctrl, clk_smpl_phase_ctrl;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic hist [0:16383];
    logic       e_en = 1'b0;
    logic [1:0] e_mux = '0;
    logic [6:0] e_drv = '0;
    logic [6:0] e_smpl = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    emmc_clk_reconfig_seq #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_mux_ctrl        (req_mux_ctrl),
        .req_drv_phase       (req_drv_phase),
        .req_smpl_phase      (req_smpl_phase),
        .clk_enable          (clk_enable),
        .ext_clk_mux_ctrl    (ext_clk_mux_ctrl),
        .clk_drv_phase_ctrl  (clk_drv_phase_ctrl),
        .clk_smpl_phase_ctrl (clk_smpl_phase_ctrl),
        .clk_ready           (clk_ready),
        .busy                (busy),
        .done                (done),
        .err_timeout         (err_timeout)
    );

    function automatic logic [20:0] obs();
        return {req_ready, busy, done, err_timeout, clk_enable,
                ext_clk_mux_ctrl, clk_drv_phase_ctrl, clk_smpl_phase_ctrl};
    endfunction

    task automatic idle(input int n);
        logic [20:0] ex;
        repeat (n) begin
            @(negedge clk);
            hist[cyc] = clk_ready;
            ex = {1'b1, 1'b0, 1'b0, 1'b0, e_en, e_mux, e_drv, e_smpl};
            n_chk++;
            if (obs() !== ex) begin
                n_fail++;
                $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, obs(), ex);
            end
        end
    endtask

    // One request from the current negedge. The clk_ready plan is pre before offset lo, 0 until hi, then 1;
    // rdy_s seen by the design in cycle c is the plan value driven two cycles earlier.
    task automatic seq(input string name, input logic pre, input int lo, input int hi,
                       input logic [1:0] m, input logic [6:0] d, input logic [6:0] s,
                       input bit nxt, input logic [1:0] m2, input logic [6:0] d2, input logic [6:0] s2);
        int c0, p, g, e, en_at, fin;
        logic ok, gto, en_b, nw;
        logic [20:0] ex;
        c0 = cyc;
        p = c0 + 1;
        req_valid = 1'b1;
        req_mux_ctrl = m;
        req_drv_phase = d;
        req_smpl_phase = s;
        clk_ready = pre;
        hist[c0] = pre;
        for (int c = c0 + 1; c < p + 2*TO + 2*S + 8; c++)
            hist[c] = (c - p < lo) ? pre : ((c - p < hi) ? 1'b0 : 1'b1);
        g = -1;
        for (int c = p; c < p + TO; c++) if (g < 0 && !hist[c-2]) g = c;
        gto = (g < 0);
        ok = 1'b0;
        en_at = 0;
        if (gto) fin = p + TO;
        else begin
            en_at = g + 2*S + 2;
            e = -1;
            for (int c = en_at; c < en_at + TO; c++) if (e < 0 && hist[c-2]) e = c;
            ok = (e >= 0);
            fin = ok ? e + 1 : en_at + TO;
        end
        for (int c = p; c <= fin; c++) begin
            @(negedge clk);
            clk_ready = hist[c];
            if (c == p) begin
                req_valid = nxt;
                if (nxt) begin
                    req_mux_ctrl = 2'($urandom);
                    req_drv_phase = 7'($urandom);
                    req_smpl_phase = 7'($urandom);
                end
            end
            if (nxt && c == p + 3) begin
                req_mux_ctrl = m2;
                req_drv_phase = d2;
                req_smpl_phase = s2;
            end
            en_b = (c == fin) ? (gto ? e_en : 1'b1) : (!gto && c >= en_at);
            nw = !gto && (c >= g + S + 2);
            ex = {c == fin, c != fin, (c == fin) && ok, (c == fin) && !ok, en_b,
                  nw ? m : e_mux, nw ? d : e_drv, nw ? s : e_smpl};
            n_chk++;
            if (obs() !== ex) begin
                n_fail++;
                $display("FAIL %s cyc=%0d (offset %0d) got=%h exp=%h", name, c, c - p, obs(), ex);
            end
        end
        if (!gto) begin
            e_mux = m;
            e_drv = d;
            e_smpl = s;
            e_en = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clk_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            hist[cyc] = clk_ready;
            n_chk++;
            if (obs() !== 21'h100000) begin
                n_fail++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs(), 21'h100000);
            end
        end
        reset_n = 1'b1;
        idle(4);
    endtask

    task automatic test_basic();
        clk_ready = 1'b0;
        idle(3);
        seq("basic", 1'b0, 0, 2*S + 2, 2'd2, 7'h25, 7'h40, 1'b0, '0, '0, '0);
        idle(3);
    endtask

    task automatic test_gate_timeout();
        clk_ready = 1'b1;
        idle(3);
        seq("gate_timeout", 1'b1, 1000, 1000, 2'($urandom), 7'($urandom), 7'($urandom), 1'b0, '0, '0, '0);
        idle(3);
    endtask

    task automatic test_enable_timeout();
        clk_ready = 1'b0;
        idle(3);
        seq("enable_timeout", 1'b0, 0, 1000, 2'd1, 7'h7f, 7'h01, 1'b0, '0, '0, '0);
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [1:0] m2;
        logic [6:0] d2, s2;
        m2 = 2'($urandom);
        d2 = 7'($urandom);
        s2 = 7'($urandom);
        clk_ready = 1'b0;
        idle(3);
        seq("b2b_first", 1'b0, 0, 2*S + 5, 2'd3, 7'h11, 7'h22, 1'b1, m2, d2, s2);
        seq("b2b_second", 1'b0, 0, 2*S + 7, m2, d2, s2, 1'b0, '0, '0, '0);
        idle(3);
    endtask

    task automatic test_timeout_tie();
        clk_ready = 1'b0;
        idle(3);
        seq("tie_done", 1'b0, 0, 2*S + TO - 1, 2'd2, 7'h0a, 7'h50, 1'b0, '0, '0, '0);
        clk_ready = 1'b0;
        idle(3);
        seq("tie_miss", 1'b0, 0, 2*S + TO, 2'd1, 7'h33, 7'h44, 1'b0, '0, '0, '0);
        idle(3);
    endtask

    task automatic test_reset_mid();
        int p;
        logic [1:0] m;
        logic [6:0] d, s;
        logic [20:0] ex;
        m = 2'($urandom);
        d = 7'($urandom);
        s = 7'($urandom);
        clk_ready = 1'b0;
        idle(3);
        req_valid = 1'b1;
        req_mux_ctrl = m;
        req_drv_phase = d;
        req_smpl_phase = s;
        p = cyc + 1;
        while (cyc < p + S + 3) begin
            @(negedge clk);
            hist[cyc] = clk_ready;
            req_valid = 1'b0;
        end
        ex = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m, d, s};
        n_chk++;
        if (obs() !== ex) begin
            n_fail++;
            $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", cyc, obs(), ex);
        end
        #2 reset_n = 1'b0;
        #1;
        n_chk++;
        if (obs() !== 21'h100000) begin
            n_fail++;
            $display("FAIL reset_mid_async got=%h exp=%h", obs(), 21'h100000);
        end
        repeat (3) begin
            @(negedge clk);
            hist[cyc] = clk_ready;
            n_chk++;
            if (obs() !== 21'h100000) begin
                n_fail++;
                $display("FAIL reset_mid_hold cyc=%0d got=%h exp=%h", cyc, obs(), 21'h100000);
            end
        end
        reset_n = 1'b1;
        e_en = 1'b0;
        e_mux = '0;
        e_drv = '0;
        e_smpl = '0;
        idle(4);
    endtask

    task automatic test_random();
        logic pre;
        int lo, hi;
        for (int i = 0; i < 20; i++) begin
            pre = 1'($urandom);
            lo = $urandom_range(0, 40);
            hi = lo + $urandom_range(0, 60);
            clk_ready = pre;
            idle(3);
            seq("random", pre, lo, hi, 2'($urandom), 7'($urandom), 7'($urandom), 1'b0, '0, '0, '0);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gate_timeout();
        test_enable_timeout();
        test_back_to_back();
        test_timeout_tie();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
